// File: rtl/ap_txn_pkg.sv
// Shared types and default widths for the ap_ctrl transaction tracker.
// Tracker states, the latency record layout and the parameter defaults used by the tracker and its queue.
package ap_txn_pkg;

    localparam int unsigned TXN_W_DEF          = 16;
    localparam int unsigned LAT_W_DEF          = 32;
    localparam int unsigned FIFO_DEPTH_DEF     = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        BUSY     = 3'd2,
        DRAIN    = 3'd3,
        FINISHED = 3'd4,
        TIMEOUT  = 3'd5
    } txn_state_e;

    typedef struct packed {
        logic [TXN_W_DEF-1:0] index;
        logic [LAT_W_DEF-1:0] latency;
    } txn_rec_t;

endpackage

// File: rtl/txn_rec_fifo.sv
// First-word-fall-through queue of latency records with full/empty flags and a flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module txn_rec_fifo
    import ap_txn_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  txn_rec_t                 i_data,
    output txn_rec_t                 o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    txn_rec_t         r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == (AW+1)'(0));
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush empties the queue and wins over push/pop.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Record storage.
    always_ff @(posedge i_clock) begin
        if (w_wr_en && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ap_txn_tracker.sv
// Watches one block's ap_ctrl handshake, queues per-transaction latency records and raises finish.
// Optional watchdog enabled by defining TXN_TIMEOUT_EN.
module ap_txn_tracker
    import ap_txn_pkg::*;
#(
    parameter int unsigned TXN_W          = TXN_W_DEF,
    parameter int unsigned LAT_W          = LAT_W_DEF,
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic [TXN_W-1:0] expected_txn,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [TXN_W-1:0] rec_index,
    output logic [LAT_W-1:0] rec_latency,
    output logic [TXN_W-1:0] txn_count,
    output logic             finish,
    output logic             overflow,
    output logic             timeout
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    txn_state_e        r_state;
    txn_state_e        w_state_nx;
    logic [TXN_W-1:0]  r_txn_count;
    logic [TXN_W-1:0]  r_target;
    logic [LAT_W-1:0]  r_lat;
    logic              r_overflow;
    logic              r_finish;
    logic              w_cmp;
    logic              w_push;
    logic              w_start_meas;
    logic [LAT_W-1:0]  w_push_lat;
    logic [TXN_W-1:0]  w_cnt_inc;
    logic              w_last;
    logic              w_pop;
    logic              w_drop;
    logic              w_wd_expire;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    txn_rec_t          w_push_rec;
    txn_rec_t          w_rd_rec;
    logic              w_unused_ready;

    assign w_unused_ready = ap_ready;
    assign w_cmp          = ap_done && ap_continue;
    assign w_cnt_inc      = r_txn_count + TXN_W'(1);
    assign w_last         = (w_cnt_inc == r_target);
    assign w_pop          = !w_empty && rec_ready;
    assign w_drop         = w_push && w_full && !w_pop;

    // Next-state and push decode.
    always_comb begin
        w_state_nx   = r_state;
        w_push       = 1'b0;
        w_start_meas = 1'b0;
        w_push_lat   = '0;
        case (r_state)
            ARMED: begin
                if (ap_start && w_cmp) begin
                    w_start_meas = 1'b1;
                    w_push       = 1'b1;
                    w_push_lat   = LAT_W'(1);
                    w_state_nx   = w_last ? DRAIN : ARMED;
                end else if (ap_start) begin
                    w_start_meas = 1'b1;
                    w_state_nx   = BUSY;
                end else begin
                    w_state_nx   = ARMED;
                end
            end
            BUSY: begin
                if (w_cmp) begin
                    w_push     = 1'b1;
                    w_push_lat = sat_inc(r_lat);
                    if (w_last) begin
                        w_state_nx = DRAIN;
                    end else if (ap_start) begin
                        w_start_meas = 1'b1;
                        w_state_nx   = BUSY;
                    end else begin
                        w_state_nx = ARMED;
                    end
                end else begin
                    w_state_nx = BUSY;
                end
            end
            DRAIN: begin
                // Leave as soon as the queue will be empty on the next edge.
                if (w_empty || (w_fifo_count == CNT_W'(1) && w_pop)) w_state_nx = FINISHED;
                else w_state_nx = DRAIN;
            end
            IDLE, FINISHED, TIMEOUT: w_state_nx = r_state;
            default: w_state_nx = IDLE;
        endcase
        if (w_wd_expire) begin
            w_state_nx = TIMEOUT;
        end else begin
            w_state_nx = w_state_nx;
        end
        if (arm) begin
            w_push       = 1'b0;
            w_start_meas = 1'b0;
            w_state_nx   = (expected_txn == TXN_W'(0)) ? DRAIN : ARMED;
        end else begin
            w_push       = w_push;
        end
    end

    // FSM state, counters and sticky status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_txn_count <= '0;
            r_target    <= '0;
            r_lat       <= '0;
            r_overflow  <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_finish <= (w_state_nx == FINISHED) || (w_state_nx == TIMEOUT);
            if (arm) begin
                r_target    <= expected_txn;
                r_txn_count <= '0;
                r_lat       <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_push) r_txn_count <= w_cnt_inc;
                if (w_start_meas) r_lat <= LAT_W'(1);
                else if (r_state == BUSY) r_lat <= sat_inc(r_lat);
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

`ifdef TXN_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;
    logic            w_wd_run;

    assign w_wd_run    = (r_state == ARMED) || (r_state == BUSY) || (r_state == DRAIN);
    assign w_wd_expire = w_wd_run && !w_push && !w_pop && (r_wdog == WD_W'(TIMEOUT_CYCLES));
    assign timeout     = r_timeout;

    // Watchdog: counts idle cycles in the watched states; any progress restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (arm) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_push || w_pop) r_wdog <= '0;
            else if (w_wd_run && !w_wd_expire) r_wdog <= r_wdog + WD_W'(1);
            if (w_wd_expire) r_timeout <= 1'b1;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        w_push_rec.index   = TXN_W_DEF'(r_txn_count);
        w_push_rec.latency = LAT_W_DEF'(w_push_lat);
    end

    txn_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_flush (arm),
        .i_push  (w_push),
        .i_pop   (rec_ready),
        .i_data  (w_push_rec),
        .o_data  (w_rd_rec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // The queue head is only meaningful while valid; hold the record fields at zero otherwise.
    assign rec_valid   = !w_empty;
    assign rec_index   = w_empty ? '0 : TXN_W'(w_rd_rec.index);
    assign rec_latency = w_empty ? '0 : LAT_W'(w_rd_rec.latency);
    assign txn_count   = r_txn_count;
    assign overflow    = r_overflow;
    assign finish      = r_finish;

endmodule
